// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants, arctangent table and atan2 FSM state type
package cordic_pkg;
   localparam int PI              = 25736;
   localparam int HALF_PI         = 12868;
   localparam int TWO_PI          = 51472;
   localparam int CORDIC_GAIN_INV = 'h136E;
   localparam int LUT_LEN         = 13;
   localparam int ATAN_LUT [LUT_LEN] = '{'h1921, 'h0ED6, 'h07D6, 'h03FA, 'h01FF, 'h00FF,
                                         'h007F, 'h003F, 'h001F, 'h000F, 'h0007, 'h0003, 'h0001};
   typedef enum logic [1:0] {IDLE, RUN, SCALE, DONE} atan_state_t;
   function automatic int atan_lut(input logic [3:0] i);
      return (int'(i) < LUT_LEN) ? ATAN_LUT[i] : 0;
   endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring iteration driving y toward zero
module cordic_vec_stage import cordic_pkg::*; #(
   parameter int W = 18
) (
   input  logic signed [W-1:0] i_x,
   input  logic signed [W-1:0] i_y,
   input  logic signed [W-1:0] i_z,
   input  logic        [3:0]   i_i,
   output logic signed [W-1:0] o_x,
   output logic signed [W-1:0] o_y,
   output logic signed [W-1:0] o_z
);
   logic signed [W-1:0] w_xs, w_ys, w_a;
   logic                w_pos;
   assign w_xs  = i_x >>> i_i;
   assign w_ys  = i_y >>> i_i;
   assign w_a   = W'(atan_lut(i_i));
   assign w_pos = !i_y[W-1];
   assign o_x   = w_pos ? i_x + w_ys : i_x - w_ys;
   assign o_y   = w_pos ? i_y - w_xs : i_y + w_xs;
   assign o_z   = w_pos ? i_z + w_a  : i_z - w_a;
endmodule

// File: rtl/cordic_atan2.sv
// cordic_atan2: iterative CORDIC vectoring unit producing atan2(y,x) and gain-compensated magnitude
module cordic_atan2 import cordic_pkg::*; #(
   parameter int WIDTH  = 16,
   parameter int FLOAT  = 13,
   parameter int STAGES = 13
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   output logic signed [WIDTH-1:0] theta_out,
   output logic signed [WIDTH-1:0] mag_out,
   output logic                    valid_out
);
   localparam int XW   = WIDTH + 2;
   localparam int PW   = XW + 14;
   localparam int MAXV = 2**(WIDTH-1) - 1;
   atan_state_t r_state, w_next;
   logic signed [XW-1:0] r_x, r_y, r_z, w_sx, w_sy, w_sz, w_xe, w_ye, w_zw, w_mag;
   logic signed [PW-1:0] w_prod, w_ms;
   logic [3:0] r_i;
   logic r_zero, r_valid, w_neg;
   logic signed [WIDTH-1:0] r_theta, r_mag;
   cordic_vec_stage #(.W(XW)) u_stage (
      .i_x(r_x), .i_y(r_y), .i_z(r_z), .i_i(r_i),
      .o_x(w_sx), .o_y(w_sy), .o_z(w_sz)
   );
   assign w_xe   = XW'(x_in);
   assign w_ye   = XW'(y_in);
   assign w_neg  = x_in[WIDTH-1];
   assign w_prod = PW'(r_x) * PW'(CORDIC_GAIN_INV);
   assign w_ms   = w_prod >>> FLOAT;
   assign w_mag  = (w_ms < 0) ? '0 : (w_ms > MAXV) ? XW'(MAXV) : XW'(w_ms);
   // a zero vector has no defined angle; report 0 instead of the accumulated table sum
   assign w_zw   = r_zero ? '0 : (r_z > XW'(PI)) ? r_z - XW'(TWO_PI) :
                   (r_z < -XW'(PI)) ? r_z + XW'(TWO_PI) : r_z;
   assign ready_out = r_state == IDLE;
   assign theta_out = r_theta;
   assign mag_out   = r_mag;
   assign valid_out = r_valid;
   // next-state: fixed-length RUN, then one SCALE and one DONE cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = valid_in ? RUN : IDLE;
         RUN:     w_next = (r_i == 4'(STAGES-1)) ? SCALE : RUN;
         SCALE:   w_next = DONE;
         default: w_next = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   // datapath: capture with left-half pre-rotation, iterate, scale/wrap, publish
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x <= '0; r_y <= '0; r_z <= '0; r_i <= '0; r_zero <= 1'b0;
         r_theta <= '0; r_mag <= '0; r_valid <= 1'b0;
      end else begin
         r_valid <= r_state == DONE;
         case (r_state)
            IDLE: if (valid_in) begin
               r_x    <= w_neg ? -w_xe : w_xe;
               r_y    <= w_neg ? -w_ye : w_ye;
               r_z    <= w_neg ? (y_in[WIDTH-1] ? -XW'(PI) : XW'(PI)) : '0;
               r_i    <= '0;
               r_zero <= (x_in == 0) && (y_in == 0);
            end
            RUN: begin
               r_x <= w_sx; r_y <= w_sy; r_z <= w_sz; r_i <= r_i + 4'd1;
            end
            SCALE: begin
               r_x <= w_mag; r_z <= w_zw;
            end
            DONE: begin
               r_theta <= r_z[WIDTH-1:0]; r_mag <= r_x[WIDTH-1:0];
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cordic_atan2.sv
// tb_cordic_atan2: directed vectors with a queue scoreboard checked by an output monitor
module tb_cordic_atan2;
   typedef struct {int th; int mg; int mtol; bit abs_th; int acc;} exp_t;
   logic clk = 0, rst = 1, valid_in = 0;
   logic signed [15:0] x_in = 0, y_in = 0;
   logic ready_out, valid_out;
   logic signed [15:0] theta_out, mag_out;
   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0, n_out = 0, n_exp = 0;
   cordic_atan2 dut (
      .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .valid_in(valid_in),
      .ready_out(ready_out), .theta_out(theta_out), .mag_out(mag_out), .valid_out(valid_out)
   );
   always #5 clk = ~clk;
   // cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act - exp > tol || exp - act > tol) begin
         errors++;
         $display("FAIL %s got %0d want %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
      end
   endtask
   // monitor: every valid_out must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && valid_out) begin
         n_out++;
         if (q.size() == 0) chk("spurious_valid_out", 1, 0, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("theta", e.abs_th ? (theta_out < 0 ? -int'(theta_out) : int'(theta_out)) : int'(theta_out), e.th, 4);
            chk("mag", int'(mag_out), e.mg, e.mtol);
            chk("latency", cyc - e.acc, 15, 0);
         end
      end
   end
   task automatic wait_ready();
      int k = 0;
      while (!ready_out && k < 100) begin @(negedge clk); k++; end
      if (!ready_out) chk("ready_timeout", 0, 1, 0);
   endtask
   task automatic wait_drain();
      int k = 0;
      while (q.size() != 0 && k < 100) begin @(negedge clk); k++; end
      chk("drain_timeout", q.size(), 0, 0);
   endtask
   task automatic send(input int x, input int y, input int th, input int mg, input int mtol, input bit abs_th);
      exp_t e;
      wait_ready();
      x_in = 16'(x); y_in = 16'(y); valid_in = 1;
      e.th = th; e.mg = mg; e.mtol = mtol; e.abs_th = abs_th; e.acc = cyc + 1;
      q.push_back(e);
      n_exp++;
      @(negedge clk);
      valid_in = 0;
   endtask
   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      chk("rst_ready", int'(ready_out), 1, 0);
      chk("rst_valid", int'(valid_out), 0, 0);
      chk("rst_theta", int'(theta_out), 0, 0);
      chk("rst_mag", int'(mag_out), 0, 0);
      send(8192, 0, 0, 8192, 8, 0);
      chk("busy_ready", int'(ready_out), 0, 0);
      wait_drain();
      send(0, 8192, 12868, 8192, 8, 0);
      send(8192, 8192, 6434, 11585, 8, 0);
      send(-8192, -8192, -19302, 11585, 8, 0);
      send(-8192, 0, 25736, 8192, 8, 1);
      send(32767, 32767, 6434, 32767, 0, 0);
      send(0, 0, 0, 0, 2, 0);
      wait_drain();
      repeat (5) @(negedge clk);
      chk("hold_theta", int'(theta_out), 0, 4);
      chk("hold_mag", int'(mag_out), 0, 2);
      // abort mid-RUN: no result may appear, and the unit must be idle right after
      send(8192, 8192, 6434, 11585, 8, 0);
      repeat (4) @(negedge clk);
      rst = 1;
      q.delete();
      n_exp--;
      @(negedge clk);
      rst = 0;
      chk("abort_ready", int'(ready_out), 1, 0);
      chk("abort_theta", int'(theta_out), 0, 0);
      repeat (20) @(negedge clk);
      send(0, -8192, -12868, 8192, 8, 0);
      wait_drain();
      // back-pressure: valid_in held during the computation is ignored
      send(8192, 0, 0, 8192, 8, 0);
      x_in = 16'sd0; y_in = 16'sd8192; valid_in = 1;
      for (int k = 0; k < 13; k++) begin
         chk("ignore_ready", int'(ready_out), 0, 0);
         @(negedge clk);
      end
      valid_in = 0;
      wait_drain();
      repeat (20) @(negedge clk);
      chk("output_count", n_out, n_exp, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
